// File: rtl/flop_equiv_monitor.sv
// Equivalence scoreboard comparing NCH spec/impl channel pairs carried as value/X-mask pairs.
// A run is warmup, then RUN_CYCLES scored samples, then done with results held until the next start.
module flop_equiv_monitor #(
    parameter int NCH        = 4,
    parameter int WIDTH      = 4,
    parameter int WARMUP     = 10,
    parameter int RUN_CYCLES = 100,
    parameter int CNT_W      = 16,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sample_en,
    input  logic [NCH-1:0]         exact_mode,
    input  logic [NCH*WIDTH-1:0]   spec_val,
    input  logic [NCH*WIDTH-1:0]   spec_x,
    input  logic [NCH*WIDTH-1:0]   impl_val,
    input  logic [NCH*WIDTH-1:0]   impl_x,
    output logic                   busy,
    output logic                   done,
    output logic [NCH-1:0]         chan_ok,
    output logic [NCH-1:0]         fail_sticky,
    output logic                   any_fail,
    output logic [CNT_W-1:0]       mismatch_cnt,
    output logic [CNT_W-1:0]       sample_cnt,
    output logic                   first_fail_valid,
    output logic [CH_W-1:0]        first_fail_chan,
    output logic [CNT_W-1:0]       first_fail_cycle,
    output logic [WIDTH-1:0]       first_fail_bits
);

    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int RW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [WW-1:0] W_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [RW-1:0] R_LAST = RW'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic [WW-1:0] warm_cnt;
    logic [RW-1:0] run_cnt;

    logic [NCH*WIDTH-1:0] eq, exact_ok, approx_ok, mode_mask, bit_ok;
    logic [NCH-1:0]       ch_ok;
    logic [CH_W-1:0]      win_chan;
    logic [WIDTH-1:0]     win_bits;
    logic                 clear_stats, do_sample;

    assign eq        = ~(spec_val ^ impl_val);
    assign exact_ok  = ~(spec_x ^ impl_x) & (spec_x | eq);
    assign approx_ok = impl_x | (~spec_x & eq);

    always_comb begin
        mode_mask = '0;
        ch_ok     = '0;
        for (int c = 0; c < NCH; c++) begin
            mode_mask[c*WIDTH +: WIDTH] = {WIDTH{exact_mode[c]}};
        end
        bit_ok = (mode_mask & exact_ok) | (~mode_mask & approx_ok);
        for (int c = 0; c < NCH; c++) begin
            ch_ok[c] = &bit_ok[c*WIDTH +: WIDTH];
        end
    end

    // Descending scan so the lowest failing channel is the last writer.
    always_comb begin
        win_chan = '0;
        win_bits = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (!ch_ok[c]) begin
                win_chan = CH_W'(c);
                win_bits = ~bit_ok[c*WIDTH +: WIDTH];
            end
        end
    end

    assign clear_stats = start && (state_q == S_IDLE || state_q == S_DONE);
    assign do_sample   = sample_en && (state_q == S_CHECK);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = (WARMUP == 0) ? S_CHECK : S_WARMUP;
            S_WARMUP:       if (warm_cnt == W_LAST) state_d = S_CHECK;
            S_CHECK:        if (sample_en && run_cnt == R_LAST) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt         <= '0;
            run_cnt          <= '0;
            chan_ok          <= '1;
            fail_sticky      <= '0;
            mismatch_cnt     <= '0;
            sample_cnt       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_chan  <= '0;
            first_fail_cycle <= '0;
            first_fail_bits  <= '0;
        end else if (clear_stats) begin
            warm_cnt         <= '0;
            run_cnt          <= '0;
            chan_ok          <= '1;
            fail_sticky      <= '0;
            mismatch_cnt     <= '0;
            sample_cnt       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_chan  <= '0;
            first_fail_cycle <= '0;
            first_fail_bits  <= '0;
        end else begin
            if (state_q == S_WARMUP) warm_cnt <= warm_cnt + 1'b1;
            if (do_sample) begin
                chan_ok     <= ch_ok;
                fail_sticky <= fail_sticky | ~ch_ok;
                run_cnt     <= run_cnt + 1'b1;
                if (!(&sample_cnt)) sample_cnt <= sample_cnt + 1'b1;
                if (!(&ch_ok)) begin
                    if (!(&mismatch_cnt)) mismatch_cnt <= mismatch_cnt + 1'b1;
                    // The record taken here reports the pre-increment sample count.
                    if (!first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_chan  <= win_chan;
                        first_fail_cycle <= sample_cnt;
                        first_fail_bits  <= win_bits;
                    end
                end
            end
        end
    end

    assign busy     = (state_q == S_WARMUP) || (state_q == S_CHECK);
    assign done     = (state_q == S_DONE);
    assign any_fail = |fail_sticky;

endmodule

// File: doc/flop_equiv_monitor.md
Name: flop_equiv_monitor

Overview:
- Synthesizable, parametrised equivalence scoreboard for spec-vs-impl flop comparison. Generalises our fixed-size simulation compare benches to NCH channels of WIDTH bits.
- Four-valued values are carried as value/X-mask pairs. Each channel has a selectable compare mode: exact, or conservative-X approximation.
- Provides a warmup window, sticky per-channel failure flags, a mismatch counter and first-failure capture.
- Sits beside the DUT pairs in regression harnesses and in emulation, where `===` is unavailable.

Parameters:
- NCH, 4, number of compared channels (>=1)
- WIDTH, 4, bits per channel (>=1)
- WARMUP, 10, clock cycles ignored after start before checking begins (>=0)
- RUN_CYCLES, 100, number of checked samples before done (>=1)
- CNT_W, 16, width of mismatch and cycle counters

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; honoured only in IDLE or DONE
- sample_en  in  1  compare this cycle (CHECK state only)
- exact_mode  in  NCH  per channel: 1 = exact, 0 = approximate
- spec_val  in  NCH*WIDTH  spec data; channel c occupies bits [c*WIDTH +: WIDTH]
- spec_x  in  NCH*WIDTH  spec X/Z mask (1 = bit unknown)
- impl_val  in  NCH*WIDTH  impl data
- impl_x  in  NCH*WIDTH  impl X/Z mask
- busy  out  1  high in WARMUP or CHECK
- done  out  1  high in DONE
- chan_ok  out  NCH  registered per-channel result of the last sample
- fail_sticky  out  NCH  channel has failed since start
- any_fail  out  1  OR of fail_sticky
- mismatch_cnt  out  CNT_W  number of failing sample cycles, saturating
- sample_cnt  out  CNT_W  number of checked samples, saturating
- first_fail_valid  out  1  first-failure record is valid
- first_fail_chan  out  max(1,$clog2(NCH))  channel of the first failure
- first_fail_cycle  out  CNT_W  sample_cnt value at the first failure
- first_fail_bits  out  WIDTH  per-bit fail mask of that channel at the first failure

Behaviour:
- Reset (rst_n low, asynchronous) forces the following; all outputs are registered.
  - state = IDLE
  - chan_ok = all 1
  - fail_sticky = 0, mismatch_cnt = 0, sample_cnt = 0
  - first_fail_* = 0
  - busy = 0, done = 0
- Per-bit check. Notation: sx = spec_x, ix = impl_x, eq = (spec_val == impl_val).
  - Exact: ok = (sx == ix) & (sx | eq).
  - Approx: ok = ix | (~sx & eq). Impl may be X anywhere; where impl is known, spec must be known and equal.
  - Channel ok = AND of its WIDTH bit results.
- States:
  - IDLE: start -> WARMUP; all statistics clear on the same edge.
  - WARMUP: an internal counter runs WARMUP cycles, then -> CHECK. If WARMUP = 0, go directly from start to CHECK.
  - CHECK: each cycle with sample_en=1 the monitor does the following. Cycles with sample_en=0 change nothing.
    - chan_ok is updated.
    - fail_sticky |= ~ok.
    - sample_cnt increments.
    - mismatch_cnt increments by 1 if any channel fails (once per cycle, not once per channel).
    - After the RUN_CYCLES-th sample -> DONE. That sample is still scored.
  - DONE: all statistics hold; start -> WARMUP with statistics cleared.
- start while busy is ignored.
- First failure: latched only on the first failing sample after start.
  - If several channels fail in the same cycle, the lowest index wins.
  - first_fail_cycle = sample_cnt before its increment (0-based).
  - first_fail_bits = inverted bit-ok vector of the winning channel.
  - Never overwritten until the next start.
- Counters saturate at all ones; there is no wrap.
- Latency: inputs sampled at edge N appear on chan_ok, fail_sticky and the counters after edge N.
- Reset asserted mid-run aborts immediately to the reset values. No partial results are retained.

Test Plan:
- NCH=4/WIDTH=4/WARMUP=10/RUN=100; all channels equal, masks 0, sample_en=1 -> done after 111 cycles from start, any_fail=0, mismatch_cnt=0, sample_cnt=100.
- Mismatch during WARMUP only (ch2 impl_val=4'hF, spec=4'h0 for cycles 1-10) -> fail_sticky=0, first_fail_valid=0.
- Approx mode ch1: spec=4'b1010 (x=0), impl x=4'b0011, val agrees on bits 3:2 -> ok. Then spec_x=4'b0001 with impl_x=0 -> fail, first_fail_bits=4'b0001.
- Exact mode ch0, impl_x=4'b1000 vs spec known at sample 5, and ch3 fails in the same cycle -> first_fail_chan=0, first_fail_cycle=5, fail_sticky=4'b1001, mismatch_cnt=1.
- CNT_W=4, every sample fails, RUN=40 -> mismatch_cnt and sample_cnt saturate at 15. start in DONE clears all to 0.
- Assert rst_n low at sample 50 with a failure latched -> asynchronous return to IDLE, all outputs at reset values. start afterwards runs a clean pass.
